// File: rtl/cpu_trace_serializer_pkg.sv
// cpu_trace_pkg: shared definitions for the CPU trace serializer.
//   - ASCII constants for the fixed frame characters
//   - Frame-state enum (one state per field, in emission order)
//   - Fixed frame lengths (time and reg digits excluded)
package cpu_trace_pkg;

    localparam logic [7:0] CH_CARET  = 8'h5e;  // '^'
    localparam logic [7:0] CH_AT     = 8'h40;  // '@'
    localparam logic [7:0] CH_COLON  = 8'h3a;  // ':'
    localparam logic [7:0] CH_SPACE  = 8'h20;  // ' '
    localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$'
    localparam logic [7:0] CH_STAR   = 8'h2a;  // '*'
    localparam logic [7:0] CH_LT     = 8'h3c;  // '<'
    localparam logic [7:0] CH_EQ     = 8'h3d;  // '='
    localparam logic [7:0] CH_HASH   = 8'h23;  // '#'
    localparam logic [7:0] CH_ZERO   = 8'h30;  // '0'
    localparam logic [7:0] CH_A_LC   = 8'h61;  // 'a'

    // Characters in a frame other than the time digits and reg digits.
    localparam int FRAME_FIXED_REG = 25;
    localparam int FRAME_FIXED_MEM = 33;

    // Start index of an 8-digit hex field (MS nibble first).
    localparam logic [2:0] HEX_MSD = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CARET,
        S_TIME,
        S_AT,
        S_PC,
        S_COLON,
        S_SP1,
        S_SIGIL,
        S_OPND,
        S_SP2,
        S_LT,
        S_EQ,
        S_DATA,
        S_HASH
    } trace_state_e;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// hex_nibble_to_ascii: combinational nibble -> lowercase ASCII hex digit.
// Ports:
//   nibble  in  4  value 0..15
//   ascii   out 8  '0'..'9' or 'a'..'f'
module hex_nibble_to_ascii
    import cpu_trace_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10)
            ascii = CH_ZERO + {4'h0, nibble};
        else
            ascii = CH_A_LC + {4'h0, nibble} - 8'd10;
    end

endmodule

// File: rtl/cpu_trace_serializer.sv
// cpu_trace_serializer: turns one CPU write-back/store event into an ASCII
// trace line, one character per clock:
//   ^<time>@<pc>: $<reg> <=<data>#   (evt_is_mem = 0)
//   ^<time>@<pc>: *<addr> <=<data>#  (evt_is_mem = 1)
// Ports:
//   clk, reset       clock (rising edge), async active-low reset
//   evt_valid/ready  event handshake; ready in IDLE and HASH
//   evt_is_mem       selects memory form
//   evt_time         packed BCD time, MS digit in top nibble
//   evt_pc/reg/addr/data  event fields, captured on accept
//   char, char_valid registered output character stream
//   busy             frame in progress (state != IDLE)
module cpu_trace_serializer
    import cpu_trace_pkg::*;
#(
    parameter int TIME_DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     evt_valid,
    output logic                     evt_ready,
    input  logic                     evt_is_mem,
    input  logic [4*TIME_DIGITS-1:0] evt_time,
    input  logic [31:0]              evt_pc,
    input  logic [4:0]               evt_reg,
    input  logic [31:0]              evt_addr,
    input  logic [31:0]              evt_data,
    output logic [7:0]               char,
    output logic                     char_valid,
    output logic                     busy
);

    trace_state_e state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;

    // Holding registers; time padded to 8 digits so the digit counter can
    // index it the same way as the hex fields.
    logic         is_mem_q;
    logic [31:0]  time_q;
    logic [31:0]  pc_q;
    logic [4:0]   reg_q;
    logic [31:0]  addr_q;
    logic [31:0]  data_q;

    logic         accept;
    logic [2:0]   time_msd;
    logic [3:0]   reg_tens;
    logic [4:0]   reg_tens10;
    logic [3:0]   reg_ones;
    logic [3:0]   nibble;
    logic [7:0]   hex_char;
    logic [7:0]   char_d;
    logic         char_valid_d;

    // Gating with reset keeps ready low while reset is held.
    assign evt_ready = reset && (state_q == S_IDLE || state_q == S_HASH);
    assign accept    = evt_valid && evt_ready;
    assign busy      = (state_q != S_IDLE);

    // Highest non-zero time digit; 0 when all digits are zero, so a
    // single '0' is emitted.
    always_comb begin
        time_msd = '0;
        for (int i = 0; i < TIME_DIGITS; i++)
            if (time_q[4*i +: 4] != 4'h0)
                time_msd = 3'(i);
    end

    // Register number 0..31 split into decimal digits.
    always_comb begin
        if (reg_q >= 5'd30)      reg_tens = 4'd3;
        else if (reg_q >= 5'd20) reg_tens = 4'd2;
        else if (reg_q >= 5'd10) reg_tens = 4'd1;
        else                     reg_tens = 4'd0;
        reg_tens10 = 5'(reg_tens * 4'd10);
        reg_ones   = 4'(reg_q - reg_tens10);
    end

    // Digit source for whichever multi-digit field is active.
    always_comb begin
        nibble = 4'h0;
        case (state_q)
            S_TIME: nibble = time_q[{cnt_q, 2'b00} +: 4];
            S_PC:   nibble = pc_q[{cnt_q, 2'b00} +: 4];
            S_OPND: begin
                if (is_mem_q)           nibble = addr_q[{cnt_q, 2'b00} +: 4];
                else if (cnt_q != 3'd0) nibble = reg_tens;
                else                    nibble = reg_ones;
            end
            S_DATA: nibble = data_q[{cnt_q, 2'b00} +: 4];
            default: nibble = 4'h0;
        endcase
    end

    hex_nibble_to_ascii u_hex (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    // State register and digit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. Digit fields count down to 0, then advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CARET;
            S_CARET: begin
                state_d = S_TIME;
                cnt_d   = time_msd;
            end
            S_TIME:  if (cnt_q == 3'd0) state_d = S_AT;    else cnt_d = cnt_q - 3'd1;
            S_AT: begin
                state_d = S_PC;
                cnt_d   = HEX_MSD;
            end
            S_PC:    if (cnt_q == 3'd0) state_d = S_COLON; else cnt_d = cnt_q - 3'd1;
            S_COLON: state_d = S_SP1;
            S_SP1:   state_d = S_SIGIL;
            S_SIGIL: begin
                state_d = S_OPND;
                if (is_mem_q)             cnt_d = HEX_MSD;
                else if (reg_q >= 5'd10)  cnt_d = 3'd1;
                else                      cnt_d = 3'd0;
            end
            S_OPND:  if (cnt_q == 3'd0) state_d = S_SP2;   else cnt_d = cnt_q - 3'd1;
            S_SP2:   state_d = S_LT;
            S_LT:    state_d = S_EQ;
            S_EQ: begin
                state_d = S_DATA;
                cnt_d   = HEX_MSD;
            end
            S_DATA:  if (cnt_q == 3'd0) state_d = S_HASH;  else cnt_d = cnt_q - 3'd1;
            S_HASH:  state_d = accept ? S_CARET : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output character for the current state; registered below, so the
    // character of a state appears on char one cycle later.
    always_comb begin
        char_d       = 8'h00;
        char_valid_d = (state_q != S_IDLE);
        case (state_q)
            S_CARET: char_d = CH_CARET;
            S_TIME:  char_d = hex_char;
            S_AT:    char_d = CH_AT;
            S_PC:    char_d = hex_char;
            S_COLON: char_d = CH_COLON;
            S_SP1:   char_d = CH_SPACE;
            S_SIGIL: char_d = is_mem_q ? CH_STAR : CH_DOLLAR;
            S_OPND:  char_d = hex_char;
            S_SP2:   char_d = CH_SPACE;
            S_LT:    char_d = CH_LT;
            S_EQ:    char_d = CH_EQ;
            S_DATA:  char_d = hex_char;
            S_HASH:  char_d = CH_HASH;
            default: char_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            char       <= 8'h00;
            char_valid <= 1'b0;
        end else begin
            char       <= char_d;
            char_valid <= char_valid_d;
        end
    end

    // Event capture on the handshake edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_mem_q <= 1'b0;
            time_q   <= '0;
            pc_q     <= '0;
            reg_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (accept) begin
            is_mem_q <= evt_is_mem;
            time_q   <= 32'(evt_time);
            pc_q     <= evt_pc;
            reg_q    <= evt_reg;
            addr_q   <= evt_addr;
            data_q   <= evt_data;
        end
    end

endmodule

// File: doc/cpu_trace_serializer.md
Name: cpu_trace_serializer

Overview:
- Sits directly upstream of cpu_checker.
- Accepts one CPU write-back or store event per handshake and serialises it into the ASCII trace line cpu_checker parses, one character per clock.
- Register form: ^<time>@<pc>: $<reg> <=<data>#
- Memory form: ^<time>@<pc>: *<addr> <=<data>#
- Drives the checker's char input from registered outputs.

Parameters:
- TIME_DIGITS, 4, number of BCD digits in evt_time (1..8). Leading zeros are suppressed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Low clears all state immediately.
- evt_valid  in  1  event present.
- evt_ready  out  1  block can accept an event this cycle.
- evt_is_mem  in  1  1 selects memory form (*addr), 0 selects register form ($reg).
- evt_time  in  4*TIME_DIGITS  simulation time as packed BCD, MS digit in the top nibble.
- evt_pc  in  32  instruction address.
- evt_reg  in  5  destination register 0..31, binary. Used when evt_is_mem=0.
- evt_addr  in  32  store address. Used when evt_is_mem=1.
- evt_data  in  32  write data.
- char  out  8  ASCII output character.
- char_valid  out  1  char holds a frame character this cycle.
- busy  out  1  a frame is being emitted.

Behaviour:
- Reset (reset=0, async): char=8'h00, char_valid=0, busy=0, evt_ready=0 while reset is asserted, state=IDLE. A frame in progress is dropped and never resumed.
- Handshake: an event is accepted on the rising edge where evt_valid and evt_ready are both 1. All evt_* fields are captured into holding registers at that edge. Inputs are don't-care afterwards.
- evt_ready=1 in IDLE and in the HASH cycle. This allows back-to-back frames with no gap.
- Latency: accept at edge N puts '^' on char at edge N+1. One character per cycle after that. There is no output backpressure.
- States and characters, in order:
  - CARET '^'
  - TIME: digits
  - AT '@'
  - PC: 8 hex digits
  - COLON ':'
  - SP1 ' '
  - SIGIL '$' or '*'
  - OPND: reg decimal, or addr as 8 hex digits
  - SP2 ' '
  - LT '<'
  - EQ '='
  - DATA: 8 hex digits
  - HASH '#'
  - then IDLE, or CARET if a new event is accepted in HASH.
- TIME: skips leading zero digits. If every digit is 0, emits a single '0'. A nibble above 9 is emitted using the hex table (lowercase letter).
- Hex fields are always 8 digits, MS nibble first, lowercase a-f, zeros kept.
- Reg field is decimal with no leading zero: 0..9 gives one digit, 10..31 gives two digits. Tens digit = 3 if reg≥30, 2 if ≥20, 1 if ≥10.
- Frame length:
  - register form: 25 + t + r characters.
  - memory form: 33 + t characters.
  - t = emitted time digits, r = emitted reg digits.
- Within each multi-digit field, a 3-bit digit counter indexes the held nibble.
- char_valid=1 exactly on frame characters. In IDLE, char=8'h00 and char_valid=0.
- busy=1 from the cycle after accept through the HASH cycle inclusive.

Decomposition:
- Shared package cpu_trace_pkg holds:
  - ASCII constants: CH_CARET, CH_AT, CH_COLON, CH_SPACE, CH_DOLLAR, CH_STAR, CH_LT, CH_EQ, CH_HASH, CH_ZERO, CH_A_LC.
  - The state enum.
  - Frame-length constants.
- One combinational sub-module, hex_nibble_to_ascii: 4-bit nibble in, 8-bit lowercase ASCII out. Used for TIME, PC, OPND-addr and DATA.

Test Plan:
- Reset then accept reg event: time=16'h0002, pc=32'h00003_0f4, reg=31, data=32'h12345678 -> char sequence "^2@000030f4: $31 <=12345678#". 28 chars, starting exactly one cycle after accept, char_valid high throughout, then char=00 and char_valid=0.
- Memory event: time=16'h0242, pc=32'h00003_0f4, addr=32'h0000_1abc, data=32'h0000_0000 -> "^242@000030f4: *00001abc <=00000000#". 36 chars.
- Edge values: time=16'h0000, reg=0 -> "^0@...: $0 <=...#". Separately time=16'h9999, reg=10 -> "9999" and "$10".
- Back-to-back: hold evt_valid=1 with two queued events. The first is accepted in IDLE, the second at the HASH edge. The next '^' follows '#' with no idle cycle. evt_ready is 0 during every other frame cycle.
- Reset mid-frame: assert reset (low) asynchronously while PC digits are being emitted. char and char_valid go to 0 without waiting for a clock edge. After release, busy=0 and evt_ready=1, and the next accepted event produces a complete fresh frame.
- Handshake hold: keep evt_valid=1 while changing evt_data during busy. The emitted DATA equals the value captured at the accept edge.
